spi_word_sched: RTL

Arbitration and sequencing controller that shares a single SPI word serializer between two word sources: the UART-to-word loader (requester 0) and a secondary loader such as a debug or self-test source (requester 1). Each requester gets a one-entry pending buffer, and a round-robin arbiter picks the next word. The block issues one word at a time to the serializer and waits for completion. It enforces a chip-select-high gap between words and a completion watchdog, and it flags end-of-program and overflow conditions. It sits between the word loaders and the SPI transmitter in the FPGA programming path.

---
 rtl/spi_word_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_word_sched.sv
// Shares one SPI word serializer between two word sources. Each source has a
// one-entry pending buffer. A round-robin arbiter picks the next word, and a
// chip-select gap and a completion watchdog are enforced between words.
module spi_word_sched #(
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          GapCycles     = 4,
    parameter int unsigned          TimeoutCycles = 4096,
    parameter logic [DataWidth-1:0] EndWord       = DataWidth'(32'h0000_0FFF)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req0_i,
    input  logic [DataWidth-1:0] data0_i,
    input  logic                 req1_i,
    input  logic [DataWidth-1:0] data1_i,
    output logic                 spi_req_o,
    output logic [DataWidth-1:0] spi_data_o,
    input  logic                 spi_done_i,
    output logic                 grant_o,
    output logic                 busy_o,
    output logic [1:0]           ovf_o,
    output logic                 err_o,
    output logic                 eop_o
);

    localparam int unsigned GapW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
    localparam int unsigned WdW  = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           pend_q, pend_d;
    logic [DataWidth-1:0] word_q [2];
    logic [DataWidth-1:0] word_d [2];
    logic [DataWidth-1:0] din [2];
    logic [1:0]           req;
    logic [1:0]           issue;
    logic                 pick;
    logic                 sel;
    logic [GapW-1:0]      gap_q, gap_d;
    logic [WdW-1:0]       wd_q, wd_d;
    logic [DataWidth-1:0] data_d;
    logic                 grant_d;
    logic                 spi_req_d;
    logic [1:0]           ovf_d;
    logic                 err_d;
    logic                 eop_d;

    assign req    = {req1_i, req0_i};
    assign din[0] = data0_i;
    assign din[1] = data1_i;
    assign issue  = {pick & sel, pick & ~sel};

    // Busy while a word is in flight or any word is still pending.
    assign busy_o = (state_q != ST_IDLE) || (pend_q != 2'b00);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, issue, watchdog and gap sequencing.
    always_comb begin
        state_d   = state_q;
        pick      = 1'b0;
        sel       = 1'b0;
        spi_req_d = 1'b0;
        data_d    = spi_data_o;
        grant_d   = grant_o;
        wd_d      = wd_q;
        gap_d     = gap_q;
        err_d     = err_o;
        eop_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'b00) begin
                    // On a tie the requester not granted last time wins.
                    unique case (pend_q)
                        2'b11:   sel = ~grant_o;
                        2'b10:   sel = 1'b1;
                        default: sel = 1'b0;
                    endcase
                    pick      = 1'b1;
                    data_d    = word_q[sel];
                    grant_d   = sel;
                    spi_req_d = 1'b1;
                    wd_d      = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_done_i || (wd_q == WdW'(TimeoutCycles - 1))) begin
                    // Done wins over a timeout that falls on the same cycle.
                    if (spi_done_i) begin
                        eop_d = (spi_data_o == EndWord);
                    end else begin
                        err_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = (GapCycles == 0) ? ST_IDLE : ST_GAP;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GapW'(GapCycles - 1)) begin
                    state_d = ST_IDLE;
                end else if (gap_q != '1) begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending-buffer capture; a slot being issued this cycle accepts a new word.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_o;
        word_d = word_q;
        for (int n = 0; n < 2; n++) begin
            if (req[n]) begin
                if (!pend_q[n] || issue[n]) begin
                    word_d[n] = din[n];
                    pend_d[n] = 1'b1;
                end else begin
                    ovf_d[n] = 1'b1;
                end
            end else if (issue[n]) begin
                pend_d[n] = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= 2'b00;
            word_q[0]  <= '0;
            word_q[1]  <= '0;
            gap_q      <= '0;
            wd_q       <= '0;
            spi_req_o  <= 1'b0;
            spi_data_o <= '0;
            grant_o    <= 1'b1;
            ovf_o      <= 2'b00;
            err_o      <= 1'b0;
            eop_o      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            word_q[0]  <= word_d[0];
            word_q[1]  <= word_d[1];
            gap_q      <= gap_d;
            wd_q       <= wd_d;
            spi_req_o  <= spi_req_d;
            spi_data_o <= data_d;
            grant_o    <= grant_d;
            ovf_o      <= ovf_d;
            err_o      <= err_d;
            eop_o      <= eop_d;
        end
    end

endmodule
